// File: rtl/rstatus_wb_stage.sv
// Memory/writeback stage: carries execute results to the regfile and redirects
// arithmetic exceptions into an $rstatus write. RSTATUS_EXC_COUNT_EN adds an exception counter.
module rstatus_wb_stage #(
  parameter int RSTATUS_REG = 30,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              x_valid,
  input  logic              x_we,
  input  logic [4:0]        x_rd,
  input  logic [DATA_W-1:0] x_result,
  input  logic              x_alu_ovf,
  input  logic              x_md_exc,
  input  logic              x_is_md,
  input  logic [DATA_W-1:0] x_status_code,
  output logic              w_reg_we,
  output logic [4:0]        w_reg_addr,
  output logic [DATA_W-1:0] w_reg_data,
  output logic              w_exc,
  output logic [15:0]       exc_count
);

  localparam logic [4:0] RS_ADDR = 5'(RSTATUS_REG);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [4:0]        rd;
    logic [DATA_W-1:0] result;
    logic              exc;
    logic [DATA_W-1:0] code;
  } stage_t;

  stage_t m_q, m_d, w_q, w_d;

  always_comb begin
    m_d = m_q;
    w_d = w_q;
    if (!stall) begin
      // Bubbles are fully zeroed so a squashed slot drives nothing stale.
      m_d = '0;
      if (x_valid && !flush) begin
        m_d.valid  = 1'b1;
        m_d.we     = x_we;
        m_d.rd     = x_rd;
        m_d.result = x_result;
        m_d.code   = x_status_code;
        m_d.exc    = x_we && (x_status_code != '0) && (x_is_md ? x_md_exc : x_alu_ovf);
      end
      w_d = m_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  always_comb begin
    if (w_q.exc) begin
      w_reg_we   = w_q.valid;
      w_reg_addr = RS_ADDR;
      w_reg_data = w_q.code;
      w_exc      = 1'b1;
    end else begin
      w_reg_we   = w_q.valid && w_q.we && (w_q.rd != 5'd0);
      w_reg_addr = w_q.rd;
      w_reg_data = w_q.result;
      w_exc      = 1'b0;
    end
  end

`ifdef RSTATUS_EXC_COUNT_EN
  logic [15:0] exc_count_q, exc_count_d;

  // Counting only on non-stalled edges keeps a frozen W from being counted twice.
  always_comb begin
    exc_count_d = exc_count_q;
    if (!stall && w_q.valid && w_q.exc && exc_count_q != 16'hFFFF)
      exc_count_d = exc_count_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) exc_count_q <= '0;
    else       exc_count_q <= exc_count_d;
  end

  assign exc_count = exc_count_q;
`else
  assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rstatus_wb_stage.sv
// Directed bench for rstatus_wb_stage; expected counter values follow RSTATUS_EXC_COUNT_EN.
module tb_rstatus_wb_stage;
`ifdef RSTATUS_EXC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        x_valid = 1'b0, x_we = 1'b0, x_alu_ovf = 1'b0, x_md_exc = 1'b0, x_is_md = 1'b0;
  logic [4:0]  x_rd = '0;
  logic [31:0] x_result = '0, x_status_code = '0;
  logic        w_reg_we, w_exc;
  logic [4:0]  w_reg_addr;
  logic [31:0] w_reg_data;
  logic [15:0] exc_count;

  int checks = 0;
  int errors = 0;

  rstatus_wb_stage #(.RSTATUS_REG(30), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .x_valid(x_valid), .x_we(x_we), .x_rd(x_rd), .x_result(x_result),
    .x_alu_ovf(x_alu_ovf), .x_md_exc(x_md_exc), .x_is_md(x_is_md),
    .x_status_code(x_status_code),
    .w_reg_we(w_reg_we), .w_reg_addr(w_reg_addr), .w_reg_data(w_reg_data),
    .w_exc(w_exc), .exc_count(exc_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Packs {we, addr, data, exc} so one comparison covers the whole write port.
  task automatic chk_w(input string tag, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic exc);
    chk(tag, {25'd0, w_reg_we, w_reg_addr, w_reg_data, w_exc}, {25'd0, we, addr, data, exc});
  endtask

  task automatic chk_cnt(input string tag, input int n);
    chk(tag, {48'd0, exc_count}, CNT_EN ? 64'(n) : 64'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [31:0] res,
                       input logic ovf, input logic mdx, input logic ismd, input logic [31:0] code);
    x_valid = 1'b1; x_we = we; x_rd = rd; x_result = res;
    x_alu_ovf = ovf; x_md_exc = mdx; x_is_md = ismd; x_status_code = code;
  endtask

  task automatic idle();
    x_valid = 1'b0; x_we = 1'b0; x_rd = '0; x_result = '0;
    x_alu_ovf = 1'b0; x_md_exc = 1'b0; x_is_md = 1'b0; x_status_code = '0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk_w("reset_out", 1'b0, 5'd0, 32'd0, 1'b0);
    chk_cnt("reset_cnt", 0);
    tick();
    reset = 1'b0;
    tick();

    // Plain add, no overflow
    issue(1, 5'd5, 32'h7, 0, 0, 0, 32'd2); tick();
    idle(); tick();
    chk_w("add_ok", 1'b1, 5'd5, 32'h7, 1'b0);

    // Add with overflow -> r30 <= 2
    issue(1, 5'd5, 32'h7, 1, 0, 0, 32'd2); tick();
    idle(); tick();
    chk_w("add_ovf", 1'b1, 5'd30, 32'd2, 1'b1);
    chk_cnt("cnt_before_retire", 0);
    tick();
    chk_cnt("cnt_add_ovf", 1);
    chk_w("bubble_after", 1'b0, 5'd0, 32'd0, 1'b0);

    // div exception, then multdiv with only ALU flag set (ignored)
    issue(1, 5'd9, 32'd99, 1, 1, 1, 32'd5); tick();
    issue(1, 5'd8, 32'd3, 1, 0, 1, 32'd5); tick();
    chk_w("div_exc", 1'b1, 5'd30, 32'd5, 1'b1);
    idle(); tick();
    chk_w("md_alu_flag_ignored", 1'b1, 5'd8, 32'd3, 1'b0);
    chk_cnt("cnt_div", 2);
    tick();

    // Exception held in W under stall
    issue(1, 5'd4, 32'h11, 1, 0, 0, 32'd7); tick();
    idle(); tick();
    chk_w("stall_pre", 1'b1, 5'd30, 32'd7, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_w("stall_hold", 1'b1, 5'd30, 32'd7, 1'b1);
      chk_cnt("stall_cnt", 2);
    end
    stall = 1'b0;
    issue(1, 5'd6, 32'h22, 0, 0, 0, 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0; idle();
    chk_cnt("cnt_after_stall", 3);
    tick();
    chk_w("flush_bubble", 1'b0, 5'd0, 32'd0, 1'b0);

    // stall and flush together: M keeps its instruction
    issue(1, 5'd10, 32'h33, 0, 0, 0, 32'd0); tick();
    issue(1, 5'd11, 32'h44, 0, 0, 0, 32'd0);
    stall = 1'b1; flush = 1'b1; tick();
    stall = 1'b0; flush = 1'b0; idle(); tick();
    chk_w("stall_beats_flush", 1'b1, 5'd10, 32'h33, 1'b0);

    // lw-style: ovf flag with zero code, rd=0
    issue(1, 5'd0, 32'h44, 1, 0, 0, 32'd0); tick();
    idle(); tick();
    chk_w("lw_r0", 1'b0, 5'd0, 32'h44, 1'b0);

    // Exception with rd=0 still writes r30
    issue(1, 5'd0, 32'h55, 1, 0, 0, 32'd3); tick();
    idle(); tick();
    chk_w("exc_rd0", 1'b1, 5'd30, 32'd3, 1'b1);

    // x_we=0 cannot raise
    issue(0, 5'd12, 32'h66, 1, 0, 0, 32'd4); tick();
    idle(); tick();
    chk_w("no_we_no_exc", 1'b0, 5'd12, 32'h66, 1'b0);
    chk_cnt("cnt_mid", 4);

    // Back-to-back exceptions, then async reset mid-cycle
    issue(1, 5'd1, 32'h0, 1, 0, 0, 32'd8); tick();
    issue(1, 5'd2, 32'h0, 1, 0, 0, 32'd9); tick();
    idle();
    chk_w("b2b_first", 1'b1, 5'd30, 32'd8, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_w("async_reset_out", 1'b0, 5'd0, 32'd0, 1'b0);
    chk_cnt("async_reset_cnt", 0);
    tick();
    reset = 1'b0;
    tick();
    chk_w("post_reset_1", 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    chk_w("post_reset_2", 1'b0, 5'd0, 32'd0, 1'b0);
    chk_cnt("post_reset_cnt", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
